// File: rtl/bcd_disp_pkg.sv
// Shared constants for the two-digit 7-segment display scanner.
// All segment codes are active low, bit order {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Anode enables are active low: bit 0 = ones digit, bit 1 = tens digit.
  localparam logic [1:0] AN_OFF  = 2'b11;
  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder. Codes 10-15 render
// as a dash, or as blank when blank_invalid is set.
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank_invalid,
  output logic [6:0] seg
);

  // Segment lookup for one BCD digit
  always_comb begin
    seg = blank_invalid ? SEG_BLANK : SEG_DASH;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = blank_invalid ? SEG_BLANK : SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_mux.sv
// Time-multiplexed driver for a pair of common-anode 7-segment digits.
// The digit pair is captured into shadow registers only at frame
// boundaries, so a displayed frame never mixes old and new digits.
module bcd_display_mux
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_INVALID = 1'b0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] digit_1,
  input  logic [3:0] digit_2,
  input  logic       en,
  input  logic       blank_lz,
  output logic [1:0] an,
  output logic [6:0] seg,
  output logic       frame_tick
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             sel;
  logic             tc;
  logic             frame_end;
  logic [3:0]       shadow_ones;
  logic [3:0]       shadow_tens;
  logic [3:0]       cur_digit;
  logic [6:0]       dec_seg;
  logic [1:0]       an_next;
  logic [6:0]       seg_next;

  assign tc        = (div == DIV_LAST);
  assign frame_end = tc && sel;
  assign cur_digit = sel ? shadow_tens : shadow_ones;

  seg7_decode u_decode (
    .code          (cur_digit),
    .blank_invalid (BLANK_INVALID),
    .seg           (dec_seg)
  );

  // Next anode/segment pattern for the slot currently selected
  always_comb begin
    an_next  = AN_ONES;
    seg_next = dec_seg;
    if (sel) begin
      if (blank_lz && (shadow_tens == 4'd0)) begin
        an_next  = AN_OFF;
        seg_next = SEG_BLANK;
      end else begin
        an_next  = AN_TENS;
      end
    end
  end

  // Slot divider, slot select and frame-synchronous shadow capture;
  // while disabled the shadows follow the inputs so enabling shows fresh data
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div         <= '0;
      sel         <= 1'b0;
      shadow_ones <= 4'd0;
      shadow_tens <= 4'd0;
      frame_tick  <= 1'b0;
    end else if (!en) begin
      div         <= '0;
      sel         <= 1'b0;
      shadow_ones <= digit_1;
      shadow_tens <= digit_2;
      frame_tick  <= 1'b0;
    end else begin
      div        <= tc ? '0 : div + DIV_W'(1);
      frame_tick <= frame_end;
      if (tc) begin
        sel <= ~sel;
      end
      if (frame_end) begin
        shadow_ones <= digit_1;
        shadow_tens <= digit_2;
      end
    end
  end

  // Registered pin drivers; a single sel bit picks the anode, so the two
  // anodes can never be low together
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else if (!en) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule
